// File: rtl/dl_region_router_pkg.sv
// Shared types for the ROM download router.
//   dl_entry_t  : one captured ioctl write (byte address + data byte)
//   dl_state_e  : issue FSM states
//   region_hit  : unsigned window test used by the per-port hit decode
package dl_router_pkg;

  // Entry address is stored at a fixed width; the router zero-extends ioctl_addr into it.
  localparam int unsigned DL_AW_MAX = 32;

  typedef struct packed {
    logic [DL_AW_MAX-1:0] addr;
    logic [7:0]           data;
  } dl_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } dl_state_e;

  // A zero size disables the region. The subtraction cannot wrap once addr >= base.
  function automatic logic region_hit(input logic [DL_AW_MAX-1:0] addr,
                                      input logic [DL_AW_MAX-1:0] base,
                                      input logic [DL_AW_MAX-1:0] size);
    return (size != '0) && (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/dl_region_router_if.sv
// SDRAM write-port bundle between the download router and the memory controller.
//   port_req  : toggle request, one bit per port (router -> sdram)
//   port_ack  : toggle acknowledge, one bit per port (sdram -> router)
//   port_addr : rebased byte address, port i at [i*AW +: AW] (router -> sdram)
//   port_d    : data byte duplicated on both lanes (router -> sdram)
interface dl_region_router_if #(
  parameter int unsigned NPORTS = 2,
  parameter int unsigned AW     = 25
);
  logic [NPORTS-1:0]    port_req;
  logic [NPORTS-1:0]    port_ack;
  logic [NPORTS*AW-1:0] port_addr;
  logic [15:0]          port_d;

  modport master (output port_req, output port_addr, output port_d, input port_ack);
  modport slave  (input port_req, input port_addr, input port_d, output port_ack);
endinterface

// File: rtl/dl_fifo2.sv
// Two-entry FIFO of captured download writes.
//   clk_i/rst_i : clock, synchronous active-high reset (flushes the FIFO)
//   push_i/din_i: write an entry; accepted when not full, or when full and popping
//   pop_i       : remove the head entry (ignored when empty)
//   dout_o      : head entry
//   full_o/empty_o : occupancy flags
module dl_fifo2
  import dl_router_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  dl_entry_t din_i,
  input  logic      pop_i,
  output dl_entry_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  dl_entry_t  mem_q [2];
  logic       wptr_q;
  logic       rptr_q;
  logic [1:0] cnt_q;
  logic       do_push;
  logic       do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign do_pop  = pop_i && !empty_o;
  // When full, the write slot is the one being read out this cycle, so it is free.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) begin
        rptr_q <= ~rptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dl_region_router.sv
// ROM download router and core reset controller.
// Captures ioctl ROM writes into a 2-entry FIFO, decodes each into the address
// regions it hits, rebases the address per region and issues toggle req/ack
// handshakes on every hit SDRAM port, waiting for all acks before the next entry.
// Ports:
//   clk_sys, reset      : clock, synchronous active-high reset
//   user_reset          : user reset request into the core reset generator
//   ioctl_downl/index/wr/addr/dout : data_io download bus (wr is a level, edge-detected here)
//   sdram               : SDRAM write-port bundle (req/ack/addr/data)
//   rom_loaded          : sticky, set when a ROM-index download ends
//   core_reset          : core reset with a delayed 1-cycle second pulse
//   cmos_wr             : NVRAM byte write strobe
//   overrun             : sticky, a ROM write arrived while the FIFO was full
module dl_region_router
  import dl_router_pkg::*;
#(
  parameter int unsigned          NPORTS    = 2,
  parameter int unsigned          AW        = 25,
  parameter logic [NPORTS*AW-1:0] PORT_BASE = {25'h000e000, 25'h0000000},
  parameter logic [NPORTS*AW-1:0] PORT_SIZE = {25'h0020000, 25'h002e000},
  parameter logic [7:0]           ROM_INDEX = 8'h00,
  parameter logic [7:0]           NV_INDEX  = 8'hff,
  parameter int unsigned          RST2_W    = 16
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     user_reset,
  input  logic                     ioctl_downl,
  input  logic [7:0]               ioctl_index,
  input  logic                     ioctl_wr,
  input  logic [AW-1:0]            ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  dl_region_router_if.master       sdram,
  output logic                     rom_loaded,
  output logic                     core_reset,
  output logic                     cmos_wr,
  output logic                     overrun
);

  logic                 wr_q;
  logic                 downl_q;
  logic [7:0]           idx_q;
  logic                 rom_loaded_q;
  logic                 overrun_q;
  logic                 core_reset_q;
  logic [RST2_W-1:0]    rst2_cnt_q;

  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  dl_entry_t            fifo_din;
  dl_entry_t            head;

  logic [NPORTS-1:0]    hit;
  logic [NPORTS*AW-1:0] rebased;
  dl_state_e            state_q;
  logic [NPORTS-1:0]    req_q;
  logic [NPORTS-1:0]    mask_q;
  logic [NPORTS*AW-1:0] addr_q;
  logic [15:0]          d_q;

  assign push     = ioctl_wr && !wr_q && ioctl_downl && (ioctl_index == ROM_INDEX);
  assign pop      = (state_q == ISSUE);
  assign fifo_din = '{addr: DL_AW_MAX'(ioctl_addr), data: ioctl_dout};

  dl_fifo2 u_fifo (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    localparam logic [AW-1:0] BASE = PORT_BASE[g*AW +: AW];
    localparam logic [AW-1:0] SIZE = PORT_SIZE[g*AW +: AW];
    assign hit[g]               = region_hit(head.addr, DL_AW_MAX'(BASE), DL_AW_MAX'(SIZE));
    assign rebased[g*AW +: AW]  = head.addr[AW-1:0] - BASE;
  end

  // Issue FSM. On reset the request bits are resynced to the acks so no port
  // sees a pending (or spurious) request afterwards.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= sdram.port_ack;
      mask_q  <= '0;
      addr_q  <= '0;
      d_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) state_q <= ISSUE;
        end
        ISSUE: begin
          addr_q <= rebased;
          d_q    <= {head.data, head.data};
          mask_q <= hit;
          if (hit == '0) begin
            state_q <= IDLE;
          end else begin
            req_q   <= req_q ^ hit;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (((req_q ^ sdram.port_ack) & mask_q) == '0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Download status and core reset generation.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_q         <= 1'b0;
      downl_q      <= 1'b0;
      idx_q        <= '0;
      rom_loaded_q <= 1'b0;
      overrun_q    <= 1'b0;
      rst2_cnt_q   <= '1;
      core_reset_q <= 1'b1;
    end else begin
      wr_q    <= ioctl_wr;
      downl_q <= ioctl_downl;
      if (ioctl_downl) idx_q <= ioctl_index;
      if (downl_q && !ioctl_downl && (idx_q == ROM_INDEX)) rom_loaded_q <= 1'b1;
      if (push && fifo_full && !pop) overrun_q <= 1'b1;
      if (user_reset || !rom_loaded_q) begin
        rst2_cnt_q <= '1;
      end else if (rst2_cnt_q != '0) begin
        rst2_cnt_q <= rst2_cnt_q - 1'b1;
      end
      core_reset_q <= user_reset || !rom_loaded_q || (rst2_cnt_q == RST2_W'(1));
    end
  end

  assign sdram.port_req  = req_q;
  assign sdram.port_addr = addr_q;
  assign sdram.port_d    = d_q;
  assign rom_loaded      = rom_loaded_q;
  assign core_reset      = core_reset_q;
  assign overrun         = overrun_q;
  assign cmos_wr         = ioctl_wr && (ioctl_index == NV_INDEX);

endmodule
